// File: rtl/pe_div_pkg.sv
// Shared types and sizing for the PE coprocessor divider.
package pe_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/cond_sub.sv
// Ripple-borrow subtractor a - b built from full-adder cells (b inverted, carry-in 1).
module cond_sub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic bn;
    assign bn        = ~b[i];
    assign diff[i]   = a[i] ^ bn ^ c[i];
    assign c[i+1]    = (a[i] & bn) | ((a[i] ^ bn) & c[i]);
  end

  // A carry out of 1 means no borrow was needed.
  assign borrow = ~c[W];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
module seq_divider
  import pe_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Handshake: start is a request taken only in IDLE (no queuing); busy marks
  // the WIDTH iteration cycles; done is a one-cycle pulse when results are valid.
  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   d;
  logic             borrow;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign t = {r, q[WIDTH-1]};

  cond_sub #(.W(WIDTH + 1)) u_sub (
    .a      (t),
    .b      ({1'b0, dvs}),
    .diff   (d),
    .borrow (borrow)
  );

  always_comb begin
    r_nxt = r;
    q_nxt = q;
    if (borrow) r_nxt = t[WIDTH-1:0];
    else        r_nxt = d[WIDTH-1:0];
    q_nxt = {q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              r     <= '0;
              q     <= dividend;
              dvs   <= divisor;
              cnt   <= '0;
            end
          end
        end
        ST_RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The partial remainder stays below the divisor, so a kept difference never uses its top bit.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_RUN) assert (borrow || !d[WIDTH]);
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=16): latency, handshake, div-by-zero, reset abort.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_errors;

  // expected {div_by_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse start, wait for done, check latency/busy span and the scoreboard entry.
  task automatic run_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    int overlap;
    logic [2*W:0] e;
    exp_q.push_back({ez, eq, er});
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat = 1;
    busy_cnt = 0;
    overlap = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy && done) overlap = 1;
    check({tag, " done_seen"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    check({tag, " busy_done_overlap"}, overlap, 0);
    e = exp_q.pop_front();
    check({tag, " quotient"}, {16'd0, quotient}, {16'd0, e[2*W-1:W]});
    check({tag, " remainder"}, {16'd0, remainder}, {16'd0, e[W-1:0]});
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e[2*W]});
    tick();
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int gap;
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_checks = 0;
    n_errors = 0;

    do_reset();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", {16'd0, quotient}, 32'd0);
    check("reset remainder", {16'd0, remainder}, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);
    check("reset state", {30'd0, dbg_state}, 32'd0);

    run_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
    run_div("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 16);
    run_div("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, 16);
    run_div("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1, 0);
    run_div("100/7 after dbz", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
    run_div("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17, 16);
    run_div("8000/3", 16'h8000, 16'd3, 16'd10922, 16'd2, 1'b0, 17, 16);

    // start held high; operands change mid-run and must only be seen at the next IDLE acceptance
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    dividend = 16'd200;
    divisor  = 16'd3;
    lat = 1;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    check("hold first latency", lat, 17);
    check("hold first quotient", {16'd0, quotient}, 32'd14);
    check("hold first remainder", {16'd0, remainder}, 32'd2);
    tick();
    gap = 1;
    while (!done && gap < 60) begin
      tick();
      gap++;
    end
    start = 1'b0;
    check("hold second gap", gap, 18);
    check("hold second quotient", {16'd0, quotient}, 32'd66);
    check("hold second remainder", {16'd0, remainder}, 32'd2);
    tick();

    // reset during iteration 8 aborts the divide
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort busy before rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort quotient", {16'd0, quotient}, 32'd0);
    check("abort remainder", {16'd0, remainder}, 32'd0);
    check("abort state", {30'd0, dbg_state}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen = 1;
      tick();
    end
    check("abort no done", seen, 0);
    run_div("1000/33 post abort", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17, 16);

    // randomised back-to-back divides, including divisor>dividend and divisor==dividend
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom_range(0, 65535));
      case (k % 3)
        0: b = 16'($urandom_range(1, 300));
        1: b = (a == 16'hFFFF) ? 16'hFFFF : 16'($urandom_range(int'(a) + 1, 65535));
        default: b = (a == 0) ? 16'd1 : a;
      endcase
      run_div("rand", a, b, a / b, a % b, 1'b0, 17, 16);
      check("rand identity", quotient * b + remainder, {16'd0, a});
      check("rand rem_lt_div", {31'd0, remainder < b}, 32'd1);
    end

    check("scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
